// File: rtl/countdown_pkg.sv
// Shared types and default sizing for the countdown timer slice.
package countdown_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cd_state_e;

  localparam int CD_WIDTH    = 8;
  localparam int CD_PRESCALE = 4;

endpackage : countdown_pkg

// File: rtl/countdown_timer_if.sv
// Load handshake between an upstream controller (master) and the countdown timer (slave).
interface countdown_timer_if #(
  parameter int WIDTH = countdown_pkg::CD_WIDTH
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             load_reload;

  modport master (
    output load_valid,
    output load_value,
    output load_reload,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  load_reload,
    output load_ready
  );

endinterface : countdown_timer_if

// File: rtl/countdown_prescaler.sv
// Enabled-cycle divider: tick is high on the enabled cycle where the phase reaches PRESCALE-1.
module countdown_prescaler #(
  parameter int PRESCALE = countdown_pkg::CD_PRESCALE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  assign tick = enable && (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule : countdown_prescaler

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse and optional auto-reload.
// Define COUNTDOWN_PRESCALE_EN to step only every PRESCALE enabled cycles.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = CD_WIDTH,
  parameter int PRESCALE = CD_PRESCALE
) (
  input  logic                clk,
  input  logic                reset_n,
  countdown_timer_if.slave    ld,
  input  logic                enable,
  input  logic                abort,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                expired
);

  cd_state_e        state_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             expired_q;
  logic [WIDTH-1:0] reload_val_q;
  logic             reload_en_q;

  logic accept_d;
  logic tick_d;
  logic step_d;
  logic last_d;
  logic abort_d;
  logic reload_d;

  assign ld.load_ready = (state_q == IDLE);
  assign count         = count_q;
  assign busy          = busy_q;
  assign expired       = expired_q;

  assign accept_d = ld.load_valid && (state_q == IDLE);
  assign abort_d  = abort && (state_q == RUN);
  assign step_d   = (state_q == RUN) && enable && tick_d && !abort;
  assign last_d   = (count_q == WIDTH'(1));
  assign reload_d = step_d && last_d && reload_en_q;

`ifdef COUNTDOWN_PRESCALE_EN
  countdown_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_d || reload_d || abort_d),
    .enable  (enable),
    .tick    (tick_d)
  );
`else
  // Every enabled cycle is a step; PRESCALE only matters with the prescaler built in.
  assign tick_d = (PRESCALE >= 1);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      busy_q       <= 1'b0;
      expired_q    <= 1'b0;
      reload_val_q <= '0;
      reload_en_q  <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (ld.load_value != '0) begin
              count_q      <= ld.load_value;
              reload_val_q <= ld.load_value;
              reload_en_q  <= ld.load_reload;
              busy_q       <= 1'b1;
              state_q      <= RUN;
            end else begin
              // A zero load expires immediately without ever entering RUN.
              count_q   <= '0;
              expired_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_d) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (step_d) begin
            if (last_d) begin
              expired_q <= 1'b1;
              if (reload_en_q) begin
                count_q <= reload_val_q;
              end else begin
                count_q <= '0;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              count_q <= count_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; the prescale scenario runs when COUNTDOWN_PRESCALE_EN is defined.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         expired;

  int n_cmp = 0;
  int n_err = 0;

  countdown_timer_if #(.WIDTH(W)) ld_if ();

  countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ld_if),
    .enable  (enable),
    .abort   (abort),
    .count   (count),
    .busy    (busy),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] c, input logic b,
                         input logic e, input logic r);
    chk({tag, ".count"},   32'(count), 32'(c));
    chk({tag, ".busy"},    32'(busy), 32'(b));
    chk({tag, ".expired"}, 32'(expired), 32'(e));
    chk({tag, ".ready"},   32'(ld_if.load_ready), 32'(r));
  endtask

  task automatic load(input logic [W-1:0] v, input logic rl);
    ld_if.load_valid  = 1'b1;
    ld_if.load_value  = v;
    ld_if.load_reload = rl;
    step();
    ld_if.load_valid  = 1'b0;
    ld_if.load_reload = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_c;
    logic         en_seq [5];
    ld_if.load_valid  = 1'b0;
    ld_if.load_value  = '0;
    ld_if.load_reload = 1'b0;

    #12;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk_all("post_reset", 8'd0, 1'b0, 1'b0, 1'b1);

`ifdef COUNTDOWN_PRESCALE_EN
    enable = 1'b1;
    load(8'd2, 1'b0);
    chk_all("ps_accept", 8'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_c = (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0;
      chk_all($sformatf("ps_e%0d", i), exp_c, (i < 8), (i == 8), (i == 8));
    end
    step();
    chk("ps_after.expired", 32'(expired), 32'd0);
`else
    // Load 3, no reload, enable high.
    enable = 1'b1;
    load(8'd3, 1'b0);
    chk_all("t1_accept", 8'd3, 1'b1, 1'b0, 1'b0);
    step(); chk_all("t1_s1", 8'd2, 1'b1, 1'b0, 1'b0);
    step(); chk_all("t1_s2", 8'd1, 1'b1, 1'b0, 1'b0);
    step(); chk_all("t1_s3", 8'd0, 1'b0, 1'b1, 1'b1);
    step(); chk_all("t1_idle", 8'd0, 1'b0, 1'b0, 1'b1);

    // Load 4 with pause cycles.
    load(8'd4, 1'b0);
    chk_all("t2_accept", 8'd4, 1'b1, 1'b0, 1'b0);
    en_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_c = 8'd3;
    step(); chk_all("t2_s1", 8'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      enable = en_seq[i];
      step();
      if (en_seq[i]) exp_c = exp_c - 8'd1;
      chk_all($sformatf("t2_c%0d", i), exp_c, (exp_c != 0), (exp_c == 0), (exp_c == 0));
    end

    // Load 2 with reload; a load attempt while running is refused.
    enable = 1'b1;
    load(8'd2, 1'b1);
    chk_all("t3_accept", 8'd2, 1'b1, 1'b0, 1'b0);
    ld_if.load_valid = 1'b1;
    ld_if.load_value = 8'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("t3_c%0d", i), (i % 2 == 0) ? 8'd1 : 8'd2, 1'b1, (i % 2 == 1), 1'b0);
    end
    ld_if.load_valid = 1'b0;
    abort = 1'b1;
    step(); abort = 1'b0;
    chk_all("t3_abort", 8'd0, 1'b0, 1'b0, 1'b1);

    // Load 5, abort on the same edge as an enabled step.
    load(8'd5, 1'b0);
    chk_all("t4_accept", 8'd5, 1'b1, 1'b0, 1'b0);
    step(); chk_all("t4_s1", 8'd4, 1'b1, 1'b0, 1'b0);
    step(); chk_all("t4_s2", 8'd3, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk_all("t4_abort", 8'd0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("t4_quiet", 8'd0, 1'b0, 1'b0, 1'b1);

    // Load 0 expires without running.
    load(8'd0, 1'b0);
    chk_all("t5_zero", 8'd0, 1'b0, 1'b1, 1'b1);
    step(); chk_all("t5_after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Reload value 1 keeps expired high continuously.
    load(8'd1, 1'b1);
    chk_all("t6_accept", 8'd1, 1'b1, 1'b0, 1'b0);
    step(); chk_all("t6_p1", 8'd1, 1'b1, 1'b1, 1'b0);
    step(); chk_all("t6_p2", 8'd1, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk_all("t6_abort", 8'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a paused run at count 7.
    enable = 1'b0;
    load(8'd7, 1'b0);
    chk_all("t7_accept", 8'd7, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("t7_async", 8'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    step(); chk_all("t7_idle", 8'd0, 1'b0, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_countdown_timer
